de4_led_sequencer: RTL and testbench

Autonomous LED pattern sequencer for the DE4 SOPC. Holds an 8-entry pattern table, programmable dwell time and a run/loop control, all in a CPU-visible Avalon-MM slave. It plays the pattern through an Avalon-MM master port wired to the 8-bit LED PIO's data register. This frees the CPU from per-step LED writes; the PIO itself is unchanged and still CPU-writable through the fabric.

---
 rtl/de4_led_seq_pkg.sv | 38 +++
 rtl/de4_led_sequencer_if.sv | 36 +++
 rtl/de4_led_pattern_regs.sv | 33 +++
 rtl/de4_led_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_de4_led_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/de4_led_seq_pkg.sv
// Shared definitions for the DE4 LED sequencer: widths, CSR word offsets,
// CSR bit positions, the sequencer state type and a dwell-load helper.
package de4_led_seq_pkg;

    localparam int LED_W   = 8;
    localparam int DWELL_W = 24;
    localparam int IDX_W   = 3;
    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 4;

    // CSR word offsets; PATTERN occupies 8..15 (address bit 3 set)
    localparam logic [ADDR_W-1:0] CSR_CTRL         = 4'd0;
    localparam logic [ADDR_W-1:0] CSR_STATUS       = 4'd1;
    localparam logic [ADDR_W-1:0] CSR_DWELL        = 4'd2;
    localparam logic [ADDR_W-1:0] CSR_PATTERN_BASE = 4'd8;

    // CTRL bit positions
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_LOOP_BIT   = 1;
    localparam int CTRL_LAST_LSB   = 4;

    // STATUS bit positions
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_IDX_LSB  = 4;
    localparam int STATUS_DONE_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    // A programmed dwell of zero still holds each pattern for one cycle
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

endpackage

// File: rtl/de4_led_sequencer_if.sv
// Bus bundle for the LED sequencer: the CPU-facing Avalon-MM CSR slave and
// the Avalon-MM master that writes the LED PIO data register.
//
// Handshake: the CSR slave has zero wait states; a write happens on any edge
// where chipselect=1 and write_n=0, and readdata is valid combinationally from
// address. The master presents a transfer while m_chipselect=1; it is accepted
// on the edge where m_waitrequest=0 and all master outputs stay frozen while
// m_waitrequest=1.
interface de4_led_sequencer_if;
    import de4_led_seq_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    logic [1:0]        m_address;
    logic              m_chipselect;
    logic              m_write_n;
    logic [31:0]       m_writedata;
    logic              m_waitrequest;

    // Sequencer side
    modport slave (
        input  address, chipselect, write_n, writedata, m_waitrequest,
        output readdata, m_address, m_chipselect, m_write_n, m_writedata
    );

    // Fabric / CPU side
    modport master (
        output address, chipselect, write_n, writedata, m_waitrequest,
        input  readdata, m_address, m_chipselect, m_write_n, m_writedata
    );

endinterface

// File: rtl/de4_led_pattern_regs.sv
// 8x8 pattern table: one synchronous write port from the CSR slave and two
// combinational read ports (CSR readback and sequencer fetch).
module de4_led_pattern_regs
    import de4_led_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [LED_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] csr_raddr_i,
    output logic [LED_W-1:0] csr_rdata_o,
    input  logic [IDX_W-1:0] seq_raddr_i,
    output logic [LED_W-1:0] seq_rdata_o
);

    logic [LED_W-1:0] mem_q [DEPTH];

    // Table storage: cleared on reset, written one entry per cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign csr_rdata_o = mem_q[csr_raddr_i];
    assign seq_rdata_o = mem_q[seq_raddr_i];

endmodule

// File: rtl/de4_led_sequencer.sv
// Autonomous LED pattern sequencer: CSR block, dwell counter and the
// IDLE/WRITE/DWELL state machine that pushes table entries to the LED PIO.
module de4_led_sequencer
    import de4_led_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    de4_led_sequencer_if.slave av,
    output state_e             dbg_state_o
);

    // CSR registers
    logic               enable_q, enable_d;
    logic               loop_q,   loop_d;
    logic               done_q,   done_d;
    logic [IDX_W-1:0]   last_q,   last_d;
    logic [DWELL_W-1:0] dwell_q,  dwell_d;

    // Sequencer registers
    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               m_cs_q;
    logic               m_wn_q;
    logic [31:0]        m_wd_q;

    logic               csr_we, ctrl_we, status_we, dwell_we, pat_we;
    logic               at_last, expire, finish;
    logic [IDX_W-1:0]   fetch_idx;
    logic [LED_W-1:0]   csr_pat, fetch_pat;
    logic [31:0]        rdata;
    logic               unused_wdata;

    assign csr_we    = av.chipselect & ~av.write_n;
    assign ctrl_we   = csr_we && (av.address == CSR_CTRL);
    assign status_we = csr_we && (av.address == CSR_STATUS);
    assign dwell_we  = csr_we && (av.address == CSR_DWELL);
    assign pat_we    = csr_we && av.address[3];

    // ">=" so a last index lowered below the running index still ends or wraps
    assign at_last = (idx_q >= last_q);
    assign expire  = (state_q == ST_DWELL) && enable_q && (cnt_q <= DWELL_W'(1));
    assign finish  = expire && at_last && !loop_q;

    // Entry the next WRITE will present: idx+1 when stepping, otherwise 0
    assign fetch_idx = ((state_q == ST_DWELL) && !at_last) ? idx_q + IDX_W'(1) : '0;

    de4_led_pattern_regs u_pattern_regs (
        .clk_i       (clk),
        .rst_i       (reset),
        .we_i        (pat_we),
        .waddr_i     (av.address[IDX_W-1:0]),
        .wdata_i     (av.writedata[LED_W-1:0]),
        .csr_raddr_i (av.address[IDX_W-1:0]),
        .csr_rdata_o (csr_pat),
        .seq_raddr_i (fetch_idx),
        .seq_rdata_o (fetch_pat)
    );

    // CSR next state: a CTRL write beats the auto-clear of enable, done set beats W1C
    always_comb begin
        enable_d = enable_q;
        loop_d   = loop_q;
        last_d   = last_q;
        dwell_d  = dwell_q;
        done_d   = done_q;
        if (ctrl_we) begin
            enable_d = av.writedata[CTRL_ENABLE_BIT];
            loop_d   = av.writedata[CTRL_LOOP_BIT];
            last_d   = av.writedata[CTRL_LAST_LSB +: IDX_W];
        end else if (finish) begin
            enable_d = 1'b0;
        end
        if (dwell_we) begin
            dwell_d = av.writedata[DWELL_W-1:0];
        end
        if (finish) begin
            done_d = 1'b1;
        end else if (status_we && av.writedata[STATUS_DONE_BIT]) begin
            done_d = 1'b0;
        end
    end

    // CSR register update
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q <= 1'b0;
            loop_q   <= 1'b0;
            last_q   <= '0;
            dwell_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            enable_q <= enable_d;
            loop_q   <= loop_d;
            last_q   <= last_d;
            dwell_q  <= dwell_d;
            done_q   <= done_d;
        end
    end

    // Sequencer FSM with registered master outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            m_cs_q  <= 1'b0;
            m_wn_q  <= 1'b1;
            m_wd_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_q) begin
                        state_q <= ST_WRITE;
                        idx_q   <= '0;
                        m_cs_q  <= 1'b1;
                        m_wn_q  <= 1'b0;
                        m_wd_q  <= {{(32-LED_W){1'b0}}, fetch_pat};
                    end
                end
                ST_WRITE: begin
                    // Transfer is held until accepted, even if enable dropped meanwhile
                    if (!av.m_waitrequest) begin
                        m_cs_q <= 1'b0;
                        m_wn_q <= 1'b1;
                        if (enable_q) begin
                            state_q <= ST_DWELL;
                            cnt_q   <= dwell_load(dwell_q);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DWELL: begin
                    if (!enable_q) begin
                        state_q <= ST_IDLE;
                    end else if (expire) begin
                        if (!at_last || loop_q) begin
                            state_q <= ST_WRITE;
                            idx_q   <= fetch_idx;
                            m_cs_q  <= 1'b1;
                            m_wn_q  <= 1'b0;
                            m_wd_q  <= {{(32-LED_W){1'b0}}, fetch_pat};
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Zero-wait-state CSR readback
    always_comb begin
        rdata = '0;
        if (av.address[3]) begin
            rdata[LED_W-1:0] = csr_pat;
        end else begin
            case (av.address)
                CSR_CTRL: begin
                    rdata[CTRL_ENABLE_BIT]              = enable_q;
                    rdata[CTRL_LOOP_BIT]                = loop_q;
                    rdata[CTRL_LAST_LSB +: IDX_W]       = last_q;
                end
                CSR_STATUS: begin
                    rdata[STATUS_BUSY_BIT]              = (state_q != ST_IDLE);
                    rdata[STATUS_IDX_LSB +: IDX_W]      = idx_q;
                    rdata[STATUS_DONE_BIT]              = done_q;
                end
                CSR_DWELL: begin
                    rdata[DWELL_W-1:0]                  = dwell_q;
                end
                default: begin
                    rdata = '0;
                end
            endcase
        end
    end

    assign unused_wdata    = ^av.writedata[31:DWELL_W];

    assign av.readdata     = rdata;
    assign av.m_address    = 2'b00;
    assign av.m_chipselect = m_cs_q;
    assign av.m_write_n    = m_wn_q;
    assign av.m_writedata  = m_wd_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_de4_led_sequencer.sv
// Bench for de4_led_sequencer: directed steps plus randomized runs, with
// accepted master writes compared against a timing/data model of the sequence.
module tb_de4_led_sequencer;
    import de4_led_seq_pkg::*;

    logic   clk;
    logic   reset;
    state_e dbg_state;
    de4_led_sequencer_if av();

    int n_tests;
    int n_fail;
    int cyc;
    int last_wr_edge;

    logic [31:0] obs_data_q[$];
    int          obs_cyc_q[$];
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [7:0]  pats [8];

    de4_led_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .av          (av),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, observed n_tests=%0d required completion", n_tests);
        $fatal(1, "watchdog");
    end

    // edge counter and accepted-write monitor
    always @(posedge clk) begin
        if (av.m_chipselect && !av.m_write_n && !av.m_waitrequest) begin
            obs_data_q.push_back(av.m_writedata);
            obs_cyc_q.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // returns just after edge e
    task automatic wait_to_edge(input int e);
        while (cyc <= e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        av.address    = a;
        av.writedata  = d;
        av.chipselect = 1'b1;
        av.write_n    = 1'b0;
        @(posedge clk);
        last_wr_edge = cyc;
        #1;
        av.chipselect = 1'b0;
        av.write_n    = 1'b1;
    endtask

    task automatic csr_write_at(input int edge_n, input logic [3:0] a, input logic [31:0] d);
        wait_to_edge(edge_n - 1);
        csr_write(a, d);
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        av.address    = a;
        av.chipselect = 1'b1;
        av.write_n    = 1'b1;
        #1;
        d = av.readdata;
        av.chipselect = 1'b0;
    endtask

    task automatic write_patterns();
        for (int i = 0; i < 8; i++) begin
            csr_write(CSR_PATTERN_BASE + 4'(i), {24'h0, pats[i]});
        end
    endtask

    task automatic check_status(input string tag, input logic busy, input logic done);
        logic [31:0] d;
        csr_read(CSR_STATUS, d);
        check({tag, "_busy"}, 32'(d[STATUS_BUSY_BIT]), 32'(busy));
        check({tag, "_done"}, 32'(d[STATUS_DONE_BIT]), 32'(done));
    endtask

    // reference: write k carries pats[k mod (last+1)], accepted at enable edge + 2 + k*period
    task automatic model_run(input int t_edge, input int n_writes, input int dwell, input int last);
        int period;
        period = ((dwell == 0) ? 1 : dwell) + 1;
        for (int k = 0; k < n_writes; k++) begin
            exp_q.push_back({24'h0, pats[k % (last + 1)]});
            exp_cyc_q.push_back(t_edge + 2 + k * period);
        end
    endtask

    function automatic int end_edge(input int t_edge, input int n_writes, input int dwell);
        return t_edge + 1 + n_writes * (((dwell == 0) ? 1 : dwell) + 1);
    endfunction

    task automatic compare_run(input string tag);
        int i;
        check({tag, "_count"}, 32'(obs_data_q.size()), 32'(exp_q.size()));
        i = 0;
        while (exp_q.size() > 0 && obs_data_q.size() > 0) begin
            check($sformatf("%s_data%0d", tag, i), obs_data_q.pop_front(), exp_q.pop_front());
            check($sformatf("%s_cycle%0d", tag, i), 32'(obs_cyc_q.pop_front()), 32'(exp_cyc_q.pop_front()));
            i++;
        end
        obs_data_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    initial begin
        logic [31:0] d;
        int t;
        int dwell;
        int last;

        n_tests = 0;
        n_fail  = 0;
        reset            = 1'b1;
        av.address       = '0;
        av.chipselect    = 1'b0;
        av.write_n       = 1'b1;
        av.writedata     = '0;
        av.m_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        check("rst_m_chipselect", 32'(av.m_chipselect), 32'(0));
        check("rst_m_write_n", 32'(av.m_write_n), 32'(1));
        check("rst_m_address", 32'(av.m_address), 32'(0));
        check("rst_m_writedata", av.m_writedata, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        for (int a = 0; a < 16; a++) begin
            csr_read(4'(a), d);
            check($sformatf("rst_rd%0d", a), d, 32'h0);
        end

        // basic three-entry run, no loop
        pats = '{8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        write_patterns();
        csr_write(CSR_DWELL, 32'd3);
        csr_write(CSR_CTRL, 32'h21);
        t = last_wr_edge;
        model_run(t, 3, 3, 2);
        wait_to_edge(end_edge(t, 3, 3) - 1);
        check_status("basic_pre_end", 1'b1, 1'b0);
        wait_to_edge(end_edge(t, 3, 3));
        check_status("basic_end", 1'b0, 1'b1);
        compare_run("basic");
        csr_write(CSR_STATUS, 32'h100);
        check_status("basic_w1c", 1'b0, 1'b0);
        csr_read(CSR_DWELL, d);
        check("rd_dwell", d, 32'd3);
        csr_read(CSR_PATTERN_BASE + 4'd2, d);
        check("rd_pattern2", d, 32'h04);
        csr_read(CSR_CTRL, d);
        check("rd_ctrl_last", 32'(d[6:4]), 32'd2);
        check("rd_ctrl_loop", 32'(d[CTRL_LOOP_BIT]), 32'd0);
        csr_write(4'd3, 32'hFFFF_FFFF);
        csr_write(4'd5, 32'hFFFF_FFFF);
        csr_read(4'd3, d);
        check("rd_reserved3", d, 32'h0);
        csr_read(4'd5, d);
        check("rd_reserved5", d, 32'h0);

        // randomized non-loop runs
        for (int r = 0; r < 4; r++) begin
            dwell = int'($urandom_range(0, 4));
            last  = int'($urandom_range(0, 7));
            foreach (pats[i]) pats[i] = 8'($urandom_range(0, 255));
            write_patterns();
            csr_write(CSR_DWELL, 32'(dwell));
            csr_write(CSR_CTRL, 32'((last << 4) | 1));
            t = last_wr_edge;
            model_run(t, last + 1, dwell, last);
            wait_to_edge(end_edge(t, last + 1, dwell) - 1);
            check_status($sformatf("rand%0d_pre_end", r), 1'b1, 1'b0);
            wait_to_edge(end_edge(t, last + 1, dwell));
            check_status($sformatf("rand%0d_end", r), 1'b0, 1'b1);
            compare_run($sformatf("rand%0d", r));
            csr_write(CSR_STATUS, 32'h100);
        end

        // loop with DWELL=0, stop mid-dwell
        pats[0] = 8'hAA;
        pats[1] = 8'h55;
        csr_write(CSR_PATTERN_BASE, 32'hAA);
        csr_write(CSR_PATTERN_BASE + 4'd1, 32'h55);
        csr_write(CSR_DWELL, 32'd0);
        csr_write(CSR_CTRL, 32'h13);
        t = last_wr_edge;
        model_run(t, 6, 0, 1);
        csr_write_at(t + 12, CSR_CTRL, 32'h12);
        check_status("loop_in_dwell", 1'b1, 1'b0);
        wait_to_edge(t + 13);
        check_status("loop_stopped", 1'b0, 1'b0);
        wait_to_edge(t + 20);
        compare_run("loop");

        // stall five cycles on the first write, stop during the stall
        pats[0] = 8'h3C;
        csr_write(CSR_PATTERN_BASE, 32'h3C);
        csr_write(CSR_DWELL, 32'd2);
        av.m_waitrequest = 1'b1;
        csr_write(CSR_CTRL, 32'h01);
        t = last_wr_edge;
        for (int e = 1; e <= 6; e++) begin
            wait_to_edge(t + e);
            check($sformatf("stall_cs%0d", e), 32'(av.m_chipselect), 32'(1));
            check($sformatf("stall_wn%0d", e), 32'(av.m_write_n), 32'(0));
            check($sformatf("stall_wd%0d", e), av.m_writedata, 32'h3C);
            if (e == 2) csr_write(CSR_CTRL, 32'h00);
        end
        av.m_waitrequest = 1'b0;
        exp_q.push_back(32'h3C);
        exp_cyc_q.push_back(t + 7);
        wait_to_edge(t + 7);
        check("stall_cs_after", 32'(av.m_chipselect), 32'(0));
        check_status("stall_end", 1'b0, 1'b0);
        wait_to_edge(t + 15);
        compare_run("stall");

        // rewrite PATTERN[1] while entry 0 dwells
        pats[0] = 8'h11;
        pats[1] = 8'h22;
        csr_write(CSR_PATTERN_BASE, 32'h11);
        csr_write(CSR_PATTERN_BASE + 4'd1, 32'h22);
        csr_write(CSR_DWELL, 32'd6);
        csr_write(CSR_CTRL, 32'h11);
        t = last_wr_edge;
        csr_write_at(t + 4, CSR_PATTERN_BASE + 4'd1, 32'hF0);
        exp_q.push_back(32'h11);
        exp_cyc_q.push_back(t + 2);
        exp_q.push_back(32'hF0);
        exp_cyc_q.push_back(t + 9);
        wait_to_edge(t + 15);
        check_status("rewrite_end", 1'b0, 1'b1);
        compare_run("rewrite");
        csr_write(CSR_STATUS, 32'h100);

        // done W1C in the finishing cycle: set wins
        pats[0] = 8'h81;
        csr_write(CSR_PATTERN_BASE, 32'h81);
        csr_write(CSR_DWELL, 32'd1);
        csr_write(CSR_CTRL, 32'h01);
        t = last_wr_edge;
        model_run(t, 1, 1, 0);
        csr_write_at(t + 3, CSR_STATUS, 32'h100);
        check_status("done_race", 1'b0, 1'b1);
        compare_run("done_race");
        csr_write(CSR_STATUS, 32'h100);
        check_status("done_cleared", 1'b0, 1'b0);

        // enable write in the finishing cycle restarts from index 0
        csr_write(CSR_CTRL, 32'h01);
        t = last_wr_edge;
        model_run(t, 1, 1, 0);
        model_run(t + 3, 1, 1, 0);
        csr_write_at(t + 3, CSR_CTRL, 32'h01);
        wait_to_edge(t + 6);
        check_status("restart_end", 1'b0, 1'b1);
        wait_to_edge(t + 10);
        compare_run("restart");

        // reset in the middle of a stalled transfer
        pats[0] = 8'h77;
        csr_write(CSR_PATTERN_BASE, 32'h77);
        av.m_waitrequest = 1'b1;
        csr_write(CSR_CTRL, 32'h01);
        t = last_wr_edge;
        wait_to_edge(t + 2);
        check("rstmid_cs_before", 32'(av.m_chipselect), 32'(1));
        reset = 1'b1;
        wait_to_edge(t + 3);
        check("rstmid_cs", 32'(av.m_chipselect), 32'(0));
        check("rstmid_wn", 32'(av.m_write_n), 32'(1));
        check("rstmid_wd", av.m_writedata, 32'h0);
        reset = 1'b0;
        av.m_waitrequest = 1'b0;
        csr_read(CSR_CTRL, d);
        check("rstmid_ctrl", d, 32'h0);
        csr_read(CSR_STATUS, d);
        check("rstmid_status", d, 32'h0);
        csr_read(CSR_DWELL, d);
        check("rstmid_dwell", d, 32'h0);
        csr_read(CSR_PATTERN_BASE, d);
        check("rstmid_pattern0", d, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        compare_run("rstmid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
